// File: rtl/alu_issue_ctrl.sv
// Operand issue stage: buffers ops in a FIFO, issues one per cycle to the
// combinational ALU and captures each result in a registered output slot.
module alu_issue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_a,
    input  logic [15:0]                in_b,
    input  logic [3:0]                 in_opcode,
    output logic [15:0]                alu_a,
    output logic [15:0]                alu_b,
    output logic [3:0]                 alu_opcode,
    output logic                       alu_en,
    input  logic [15:0]                alu_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_result,
    output logic [3:0]                 out_opcode,
    output logic                       out_err,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [15:0]                issue_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [15:0]   out_result_q, out_result_d;
    logic [3:0]    out_opcode_q, out_opcode_d;
    logic          out_err_q, out_err_d;
    logic [15:0]   issue_count_q, issue_count_d;
    logic          push;
    logic          issue;
    logic          illegal;

    assign head     = mem_q[rd_ptr_q];
    assign in_ready = rst_n && (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    // Issue also gated by reset so nothing reaches the ALU while held.
    assign issue    = rst_n && (count_q != '0) && (!out_valid_q || out_ready);

    always_comb begin
        illegal = 1'b1;
        case (head.op)
            4'b0000, 4'b0001, 4'b0010, 4'b0100: illegal = 1'b0;
            default:                            illegal = 1'b1;
        endcase
    end

    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_opcode_d  = out_opcode_q;
        out_err_d     = out_err_q;
        issue_count_d = issue_count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{a: in_a, b: in_b, op: in_opcode};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (issue) begin
            rd_ptr_d      = rd_ptr_q + AW'(1);
            out_valid_d   = 1'b1;
            out_result_d  = alu_result;
            out_opcode_d  = head.op;
            out_err_d     = illegal;
            issue_count_d = issue_count_q + 16'd1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (push && !issue) begin
            count_d = count_q + CW'(1);
        end else if (issue && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_opcode_q  <= '0;
            out_err_q     <= 1'b0;
            issue_count_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_opcode_q  <= out_opcode_d;
            out_err_q     <= out_err_d;
            issue_count_q <= issue_count_d;
        end
    end

    assign alu_en      = issue;
    assign alu_a       = issue ? head.a : '0;
    assign alu_b       = issue ? head.b : '0;
    assign alu_opcode  = issue ? head.op : '0;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_opcode  = out_opcode_q;
    assign out_err     = out_err_q;
    assign occupancy   = count_q;
    assign issue_count = issue_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed ops, queued expectations,
// monitor compares every result handed downstream.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [3:0]  in_opcode = '0;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_opcode;
    logic        alu_en;
    logic [15:0] alu_result;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic [3:0]  out_opcode;
    logic        out_err;
    logic [2:0]  occupancy;
    logic [15:0] issue_count;

    int n_checks = 0;
    int n_fail = 0;
    logic [20:0] sb[$];

    alu_issue_ctrl #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_en(alu_en), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_opcode(out_opcode),
        .out_err(out_err), .occupancy(occupancy),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    // Reference ALU: signed compares, zero for unsupported opcodes.
    always_comb begin
        alu_result = '0;
        if (alu_en) begin
            case (alu_opcode)
                4'b0000: alu_result = alu_a + alu_b;
                4'b0001: alu_result = alu_a - alu_b;
                4'b0010: alu_result = {15'd0, $signed(alu_a) > $signed(alu_b)};
                4'b0100: alu_result = {15'd0, $signed(alu_a) <= $signed(alu_b)};
                default: alu_result = '0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {16'd0, out_result}, 32'hdead);
            end else begin
                logic [20:0] e;
                e = sb.pop_front();
                chk("out_result", {16'd0, out_result}, {16'd0, e[20:5]});
                chk("out_opcode", {28'd0, out_opcode}, {28'd0, e[4:1]});
                chk("out_err", {31'd0, out_err}, {31'd0, e[0]});
            end
        end
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input logic [15:0] res,
                        input logic err, input logic exp_acc);
        logic acc;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_opcode = op;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("accept", {31'd0, acc}, {31'd0, exp_acc});
        if (acc) sb.push_back({res, op, err});
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", {31'd0, t < 50}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_alu_en", {31'd0, alu_en}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", {16'd0, out_result}, 32'd0);
        chk("rst_out_opcode", {28'd0, out_opcode}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
        chk("rst_issue_count", {16'd0, issue_count}, 32'd0);
        rst_n = 1'b1;

        push(16'h0003, 16'h0004, 4'b0000, 16'h0007, 1'b0, 1'b1);
        chk("add_alu_en", {31'd0, alu_en}, 32'd1);
        chk("add_alu_a", {16'd0, alu_a}, 32'h3);
        chk("add_alu_b", {16'd0, alu_b}, 32'h4);
        chk("add_occupancy", {29'd0, occupancy}, 32'd1);
        @(posedge clk);
        #1;
        chk("add_out_valid", {31'd0, out_valid}, 32'd1);
        chk("add_alu_en_off", {31'd0, alu_en}, 32'd0);
        chk("add_issue_count", {16'd0, issue_count}, 32'd1);
        drain();

        push(16'h0000, 16'h0001, 4'b0001, 16'hFFFF, 1'b0, 1'b1);
        push(16'h0005, 16'h0003, 4'b0010, 16'h0001, 1'b0, 1'b1);
        push(16'h8000, 16'h0001, 4'b0100, 16'h0001, 1'b0, 1'b1);
        chk("stream_alu_en", {31'd0, alu_en}, 32'd1);
        chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
        drain();
        chk("stream_issue_count", {16'd0, issue_count}, 32'd4);

        push(16'h1234, 16'h1111, 4'b0011, 16'h0000, 1'b1, 1'b1);
        drain();
        chk("illegal_issue_count", {16'd0, issue_count}, 32'd5);

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push(16'h0100 + 16'(i), 16'h0010, 4'b0000,
                 16'h0110 + 16'(i), 1'b0, 1'b1);
        push(16'hAAAA, 16'h0001, 4'b0000, 16'hAAAB, 1'b0, 1'b0);
        chk("bp_occupancy", {29'd0, occupancy}, 32'd4);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_alu_en", {31'd0, alu_en}, 32'd0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_valid_4", {31'd0, out_valid}, 32'd1);
        chk("bp_sb_4", sb.size(), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_valid_5", {31'd0, out_valid}, 32'd0);
        chk("bp_sb_5", sb.size(), 32'd0);
        chk("bp_issue_count", {16'd0, issue_count}, 32'd10);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            push(16'h0020 + 16'(i), 16'h0001, 4'b0000,
                 16'h0021 + 16'(i), 1'b0, 1'b1);
        chk("sim_occ_before", {29'd0, occupancy}, 32'd2);
        out_ready = 1'b1;
        push(16'h0023, 16'h0001, 4'b0000, 16'h0024, 1'b0, 1'b1);
        chk("sim_occ_after", {29'd0, occupancy}, 32'd2);
        for (int i = 0; i < 10; i++)
            push(16'(i * 16'h0111), 16'(i), 4'b0001,
                 16'(i * 16'h0111) - 16'(i), 1'b0, 1'b1);
        drain();
        chk("wrap_issue_count", {16'd0, issue_count}, 32'd24);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push(16'h0040 + 16'(i), 16'h0002, 4'b0000,
                 16'h0042 + 16'(i), 1'b0, 1'b1);
        chk("mid_occupancy", {29'd0, occupancy}, 32'd3);
        chk("mid_out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        chk("mid_rst_occ", {29'd0, occupancy}, 32'd0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_result", {16'd0, out_result}, 32'd0);
        chk("mid_rst_count", {16'd0, issue_count}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(16'h0001, 16'h0001, 4'b0000, 16'h0002, 1'b0, 1'b1);
        drain();
        chk("post_rst_count", {16'd0, issue_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
